musteri_hizmet_sirasi: RTL and testbench
========================================

Name: musteri_hizmet_sirasi

Overview:
- Scheduler that shares one service desk between two customers, each presenting a request and a 2-bit priority.
- Compares the two priorities (greater / equal / less) to pick who is served; equal priorities alternate round-robin.
- Runs a fixed-length, non-preemptive service window with a down-counter and a completion pulse.
- Drives registered red/green/yellow indicator lights from the comparison latched at each grant decision.

Parameters:
- SERVICE_CYCLES, 4, number of cycles a granted customer is served; legal range 1..15.
- CW, 4, width of the remaining-cycles counter; must satisfy 2^CW > SERVICE_CYCLES.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- istek1  input  1  customer 1 service request (level).
- istek2  input  1  customer 2 service request (level).
- musteri1  input  2  customer 1 priority, unsigned.
- musteri2  input  2  customer 2 priority, unsigned.
- hizmet1  output  1  customer 1 is being served.
- hizmet2  output  1  customer 2 is being served.
- bitti  output  1  one-cycle pulse, service just completed.
- kalan  output  CW  remaining service cycles, including the current one.
- kirmizi  output  1  latched decision: musteri1 > musteri2.
- yesil  output  1  latched decision: musteri1 < musteri2.
- sari  output  1  latched decision: musteri1 == musteri2.

Behaviour:
- Reset (synchronous, active-high; wins over everything):
  - State goes to IDLE; all outputs are 0.
  - Round-robin pointer is set so customer 1 wins the first tie.
- States: IDLE, SERVE1, SERVE2.
- IDLE, decision made from inputs sampled in the same cycle:
  - No request: stay in IDLE.
  - Only istek1: go to SERVE1. Only istek2: go to SERVE2.
  - Both requesting: the larger priority wins.
  - Both requesting with equal priority: the customer not served last wins, then the round-robin pointer updates.
- Lights on a grant:
  - On every grant, latch the musteri1/musteri2 comparison into kirmizi/yesil/sari, including single-request grants. Exactly one is high.
  - Lights hold until the next grant or reset. All three are 0 only before the first grant.
- Latency: a request sampled in IDLE at cycle t gives hizmetN=1 and kalan=SERVICE_CYCLES at t+1.
- SERVEn:
  - hizmetN is high for exactly SERVICE_CYCLES cycles; hizmet1 and hizmet2 are never both high.
  - kalan counts SERVICE_CYCLES, ..., 1 on those cycles.
  - The cycle after kalan==1: state is IDLE, hizmetN=0, kalan=0, bitti=1 for that one cycle.
  - That cycle is also a decision cycle, so back-to-back services have exactly one idle cycle between them.
- Non-preemptive:
  - Request or priority changes during service are ignored.
  - Dropping istekN mid-service does not shorten the service.
- Round-robin pointer updates on every grant, recording the customer served.
- SERVICE_CYCLES=1: hizmet lasts one cycle, with kalan=1.
- Reset mid-service: service aborts with no bitti; next cycle all outputs are 0.

Test Plan:
- Reset held 2 cycles -> hizmet1=hizmet2=bitti=0, kalan=0, kirmizi=yesil=sari=0.
- istek1=1 alone at t, SERVICE_CYCLES=4, musteri1=1, musteri2=0 -> hizmet1=1 over t+1..t+4, kalan 4,3,2,1; bitti=1 and kalan=0 at t+5; kirmizi=1.
- istek1=istek2=1 held, musteri1=3, musteri2=1 -> customer 1 served every service window, hizmet2 never asserts, kirmizi=1.
- istek1=istek2=1 held, musteri1=musteri2=2 after reset -> grant order 1,2,1,2 with one idle cycle between windows; sari=1 throughout.
- musteri1=0, musteri2=3, both requesting -> hizmet2 and yesil=1; drop istek2 after 1 service cycle -> hizmet2 still lasts the full 4 cycles, then bitti=1.
- Reset asserted during the 2nd cycle of SERVE2 -> next cycle all outputs 0 with no bitti; then an equal-priority tie is granted to customer 1.

Source files
------------

// File: rtl/musteri_hizmet_sirasi.sv
// Service-desk scheduler shared by two customers.
// A grant is decided only while idle: a single request wins outright, two
// requests are settled by priority, and equal priorities alternate between
// the customers. A granted service runs for exactly SERVICE_CYCLES cycles and
// cannot be preempted. The priority comparison seen at each grant is held on
// the red/green/yellow lights until the next grant.
module musteri_hizmet_sirasi #(
    parameter int SERVICE_CYCLES = 4,
    parameter int CW             = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          istek1,
    input  logic          istek2,
    input  logic [1:0]    musteri1,
    input  logic [1:0]    musteri2,
    output logic          hizmet1,
    output logic          hizmet2,
    output logic          bitti,
    output logic [CW-1:0] kalan,
    output logic          kirmizi,
    output logic          yesil,
    output logic          sari
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE1 = 2'd1,
        SERVE2 = 2'd2
    } state_t;

    localparam logic [CW-1:0] FULL_COUNT = CW'(SERVICE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(1);

    state_t state;

    // High when customer 2 received the most recent grant; the other
    // customer then takes the next tie.
    logic last_two;

    // Priority comparison, also the value latched onto the lights.
    logic gt;
    logic lt;
    logic eq;

    // Who would be granted if the desk were idle this cycle.
    logic pick1;
    logic pick2;

    // Compare the two priorities and resolve who would win a grant now.
    always_comb begin
        gt    = (musteri1 > musteri2);
        lt    = (musteri1 < musteri2);
        eq    = (musteri1 == musteri2);
        pick1 = 1'b0;
        pick2 = 1'b0;
        if (istek1 && istek2) begin
            if (gt) begin
                pick1 = 1'b1;
            end else if (lt) begin
                pick2 = 1'b1;
            end else if (last_two) begin
                pick1 = 1'b1;
            end else begin
                pick2 = 1'b1;
            end
        end else if (istek1) begin
            pick1 = 1'b1;
        end else if (istek2) begin
            pick2 = 1'b1;
        end
    end

    // Scheduler state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_two <= 1'b1;
            hizmet1  <= 1'b0;
            hizmet2  <= 1'b0;
            bitti    <= 1'b0;
            kalan    <= '0;
            kirmizi  <= 1'b0;
            yesil    <= 1'b0;
            sari     <= 1'b0;
        end else begin
            // The completion pulse lasts a single cycle by default.
            bitti <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick1 || pick2) begin
                        state    <= pick1 ? SERVE1 : SERVE2;
                        hizmet1  <= pick1;
                        hizmet2  <= pick2;
                        kalan    <= FULL_COUNT;
                        last_two <= pick2;
                        kirmizi  <= gt;
                        yesil    <= lt;
                        sari     <= eq;
                    end
                end
                SERVE1, SERVE2: begin
                    // Requests and priorities are ignored here, so a service
                    // always runs to its full length.
                    if (kalan == LAST_COUNT) begin
                        state   <= IDLE;
                        hizmet1 <= 1'b0;
                        hizmet2 <= 1'b0;
                        kalan   <= '0;
                        bitti   <= 1'b1;
                    end else begin
                        kalan <= kalan - LAST_COUNT;
                    end
                end
                default: begin
                    state   <= IDLE;
                    hizmet1 <= 1'b0;
                    hizmet2 <= 1'b0;
                    kalan   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_musteri_hizmet_sirasi.sv
// Bench for the two-customer service scheduler: directed scenarios with
// hand-computed expectations plus a cycle-by-cycle comparison against a
// window-based model of the schedule.
module tb_musteri_hizmet_sirasi;

    localparam int S  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          istek1 = 1'b0;
    logic          istek2 = 1'b0;
    logic [1:0]    musteri1 = 2'd0;
    logic [1:0]    musteri2 = 2'd0;
    logic          hizmet1;
    logic          hizmet2;
    logic          bitti;
    logic [CW-1:0] kalan;
    logic          kirmizi;
    logic          yesil;
    logic          sari;

    int tests  = 0;
    int failed = 0;

    musteri_hizmet_sirasi #(.SERVICE_CYCLES(S), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .istek1   (istek1),
        .istek2   (istek2),
        .musteri1 (musteri1),
        .musteri2 (musteri2),
        .hizmet1  (hizmet1),
        .hizmet2  (hizmet2),
        .bitti    (bitti),
        .kalan    (kalan),
        .kirmizi  (kirmizi),
        .yesil    (yesil),
        .sari     (sari)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a service is a window anchored at its grant cycle g. Cycles
    // g+1..g+S serve, cycle g+S+1 carries the completion pulse, and any cycle
    // with no open window (d > S) is a decision cycle.
    int    cyc = 0;
    bit    model_valid = 0;
    bit    m_active = 0;
    int    m_g = 0;
    int    m_who = 0;
    int    m_last = 2;
    bit    m_r = 0, m_y = 0, m_s = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0;
            m_who = 0;
            m_last = 2;
            m_r = 0; m_y = 0; m_s = 0;
            model_valid = 1;
        end else if (model_valid) begin
            if (!m_active || (cyc - m_g > S)) begin
                int w;
                w = 0;
                if (istek1 && istek2) begin
                    if (musteri1 > musteri2)      w = 1;
                    else if (musteri2 > musteri1) w = 2;
                    else                          w = (m_last == 1) ? 2 : 1;
                end else if (istek1) w = 1;
                else if (istek2)     w = 2;
                if (w != 0) begin
                    m_active = 1;
                    m_g = cyc;
                    m_who = w;
                    m_last = w;
                    m_r = (musteri1 > musteri2);
                    m_y = (musteri1 < musteri2);
                    m_s = (musteri1 == musteri2);
                end
            end
        end
        cyc++;
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (model_valid) begin
            int d, eh1, eh2, eb, ek;
            d   = cyc - m_g;
            eh1 = (m_active && d >= 1 && d <= S && m_who == 1) ? 1 : 0;
            eh2 = (m_active && d >= 1 && d <= S && m_who == 2) ? 1 : 0;
            ek  = (m_active && d >= 1 && d <= S) ? (S - d + 1) : 0;
            eb  = (m_active && d == S + 1) ? 1 : 0;
            chk("model_hizmet1", int'(hizmet1), eh1);
            chk("model_hizmet2", int'(hizmet2), eh2);
            chk("model_kalan", int'(kalan), ek);
            chk("model_bitti", int'(bitti), eb);
            chk("model_lights", int'({kirmizi, yesil, sari}), int'({m_r, m_y, m_s}));
            chk("exclusive_hizmet", int'(hizmet1 & hizmet2), 0);
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; istek1 = 1'b0; istek2 = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int h1cnt, h2cnt, nw;
        int order[4];
        logic prev1, prev2;

        // Reset held two cycles: everything idle and dark.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hizmet", int'({hizmet1, hizmet2}), 0);
        chk("rst_bitti", int'(bitti), 0);
        chk("rst_kalan", int'(kalan), 0);
        chk("rst_lights", int'({kirmizi, yesil, sari}), 0);

        // Single request from customer 1.
        istek1 = 1'b1; musteri1 = 2'd1; musteri2 = 2'd0;
        @(negedge clk);
        istek1 = 1'b0;
        chk("single_h1", int'(hizmet1), 1);
        chk("single_k4", int'(kalan), 4);
        chk("single_red", int'({kirmizi, yesil, sari}), 3'b100);
        for (int k = 3; k >= 1; k--) begin
            @(negedge clk);
            chk("single_count", int'(kalan), k);
            chk("single_h1_hold", int'(hizmet1), 1);
        end
        @(negedge clk);
        chk("single_bitti", int'(bitti), 1);
        chk("single_end_k", int'(kalan), 0);
        chk("single_end_h1", int'(hizmet1), 0);
        @(negedge clk);
        chk("single_pulse_once", int'(bitti), 0);
        chk("single_lights_hold", int'({kirmizi, yesil, sari}), 3'b100);

        // Both requesting, customer 1 strictly higher: customer 1 every window.
        do_reset(1);
        istek1 = 1'b1; istek2 = 1'b1; musteri1 = 2'd3; musteri2 = 2'd1;
        h1cnt = 0; h2cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            h1cnt += int'(hizmet1);
            h2cnt += int'(hizmet2);
        end
        chk("prio_h1_cycles", h1cnt, 12);
        chk("prio_h2_cycles", h2cnt, 0);
        chk("prio_red", int'({kirmizi, yesil, sari}), 3'b100);

        // Equal priorities after reset: grants alternate 1,2,1,2.
        do_reset(1);
        istek1 = 1'b1; istek2 = 1'b1; musteri1 = 2'd2; musteri2 = 2'd2;
        nw = 0; prev1 = 1'b0; prev2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (nw < 4 && hizmet1 && !prev1) begin order[nw] = 1; nw++; end
            if (nw < 4 && hizmet2 && !prev2) begin order[nw] = 2; nw++; end
            prev1 = hizmet1; prev2 = hizmet2;
        end
        chk("rr_windows", nw, 4);
        chk("rr_order0", order[0], 1);
        chk("rr_order1", order[1], 2);
        chk("rr_order2", order[2], 1);
        chk("rr_order3", order[3], 2);
        chk("rr_yellow", int'({kirmizi, yesil, sari}), 3'b001);

        // Customer 2 higher, then both requests drop after one service cycle.
        do_reset(1);
        istek1 = 1'b1; istek2 = 1'b1; musteri1 = 2'd0; musteri2 = 2'd3;
        @(negedge clk);
        istek1 = 1'b0; istek2 = 1'b0;
        chk("drop_h2", int'(hizmet2), 1);
        chk("drop_green", int'({kirmizi, yesil, sari}), 3'b010);
        h2cnt = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            h2cnt += int'(hizmet2);
        end
        chk("drop_full_len", h2cnt, 4);
        @(negedge clk);
        chk("drop_bitti", int'(bitti), 1);
        chk("drop_h2_off", int'(hizmet2), 0);

        // Reset during the second serving cycle of customer 2.
        do_reset(1);
        istek2 = 1'b1; musteri1 = 2'd0; musteri2 = 2'd3;
        @(negedge clk);
        chk("abort_first", int'(kalan), 4);
        @(negedge clk);
        chk("abort_second", int'(kalan), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_outputs", int'({hizmet1, hizmet2, bitti, kirmizi, yesil, sari}), 0);
        chk("abort_kalan", int'(kalan), 0);
        istek1 = 1'b1; istek2 = 1'b1; musteri1 = 2'd1; musteri2 = 2'd1;
        @(negedge clk);
        chk("abort_tie_h1", int'(hizmet1), 1);
        chk("abort_tie_yellow", int'({kirmizi, yesil, sari}), 3'b001);
        istek1 = 1'b0; istek2 = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
